// File: rtl/drac_pkg.sv
// Shared types and helpers for the Lagarto data-cache response path.
// The misalignment rule lives here so that the align unit and future forwarding logic agree.
package drac_pkg;

    localparam int unsigned DCACHE_RESP_TIMEOUT = 1024;
    localparam int unsigned TAG_W_DEF           = 5;

    typedef enum logic [2:0] {
        LD  = 3'd0,
        LW  = 3'd1,
        LWU = 3'd2,
        LH  = 3'd3,
        LHU = 3'd4,
        LB  = 3'd5,
        LBU = 3'd6
    } instr_type_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RESP = 2'd1,
        DRAIN     = 2'd2,
        HOLD      = 2'd3
    } dc_state_t;

    typedef struct packed {
        logic                 valid;
        logic [63:0]          data;
        logic [TAG_W_DEF-1:0] rd;
        logic                 misaligned;
    } resp_dcache_cpu_t;

    // An access is misaligned when the offset is not a multiple of its size.
    function automatic logic is_misaligned(input instr_type_t t, input logic [2:0] off);
        logic mis;
        mis = 1'b0;
        case (t)
            LH, LHU: mis = off[0];
            LW, LWU: mis = |off[1:0];
            LD:      mis = |off;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lagarto_dcache_resp_if.sv
// Load/store request, cache response and CPU response signals of the dcache response block.
// The slave modport is the block itself; the master modport is the surrounding pipeline.
interface lagarto_dcache_resp_if
    import drac_pkg::*;
#(
    parameter int unsigned TAG_W = TAG_W_DEF
) ();

    logic              ld_req_valid_i;
    logic              ld_req_gnt_i;
    instr_type_t       ld_instr_type_i;
    logic [2:0]        ld_offset_i;
    logic [TAG_W-1:0]  ld_rd_i;
    logic              kill_i;
    logic              st_req_valid_i;
    logic              st_req_gnt_i;
    logic              ld_resp_valid_i;
    logic [63:0]       ld_resp_rdata_i;
    logic              resp_valid_o;
    logic              resp_ready_i;
    logic [63:0]       resp_data_o;
    logic [TAG_W-1:0]  resp_rd_o;
    logic              resp_misaligned_o;
    logic              st_done_o;
    logic              busy_o;
    logic              timeout_o;

    modport slave (
        input  ld_req_valid_i, ld_req_gnt_i, ld_instr_type_i, ld_offset_i, ld_rd_i,
        input  kill_i, st_req_valid_i, st_req_gnt_i,
        input  ld_resp_valid_i, ld_resp_rdata_i, resp_ready_i,
        output resp_valid_o, resp_data_o, resp_rd_o, resp_misaligned_o,
        output st_done_o, busy_o, timeout_o
    );

    modport master (
        output ld_req_valid_i, ld_req_gnt_i, ld_instr_type_i, ld_offset_i, ld_rd_i,
        output kill_i, st_req_valid_i, st_req_gnt_i,
        output ld_resp_valid_i, ld_resp_rdata_i, resp_ready_i,
        input  resp_valid_o, resp_data_o, resp_rd_o, resp_misaligned_o,
        input  st_done_o, busy_o, timeout_o
    );

endinterface

// File: rtl/lagarto_ld_align.sv
// Combinational load field extraction: shift the 64-bit word down to the byte offset,
// then sign/zero-extend by access type. Misaligned accesses return zero.
module lagarto_ld_align
    import drac_pkg::*;
(
    input  instr_type_t type_i,
    input  logic [2:0]  offset_i,
    input  logic [63:0] rdata_i,
    output logic [63:0] data_o,
    output logic        misaligned_o
);

    logic [63:0] sh;
    logic        mis;

    assign sh           = rdata_i >> {offset_i, 3'b000};
    assign mis          = is_misaligned(type_i, offset_i);
    assign misaligned_o = mis;

    always_comb begin
        data_o = '0;
        if (!mis) begin
            case (type_i)
                LB:      data_o = {{56{sh[7]}},  sh[7:0]};
                LBU:     data_o = {56'd0,        sh[7:0]};
                LH:      data_o = {{48{sh[15]}}, sh[15:0]};
                LHU:     data_o = {48'd0,        sh[15:0]};
                LW:      data_o = {{32{sh[31]}}, sh[31:0]};
                LWU:     data_o = {32'd0,        sh[31:0]};
                LD:      data_o = sh;
                default: data_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/lagarto_dcache_resp.sv
// Tracks the single outstanding dcache load, formats its result for writeback with a
// valid/ready handshake, and produces store acks, kill draining and a watchdog timeout.
module lagarto_dcache_resp
    import drac_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DCACHE_RESP_TIMEOUT,
    parameter int unsigned TAG_W          = TAG_W_DEF
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    lagarto_dcache_resp_if.slave   bus
);

    localparam int unsigned      CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    dc_state_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    instr_type_t        type_q;
    logic [2:0]         offset_q;
    logic [TAG_W-1:0]   rd_q;
    resp_dcache_cpu_t   resp_q;
    logic               st_done_q;

    logic               ld_fire;
    logic               capture;
    logic               load_resp;
    logic               clear_resp;
    logic               timeout;
    logic [63:0]        align_data;
    logic               align_mis;

    assign ld_fire = bus.ld_req_valid_i & bus.ld_req_gnt_i;

    // Alignment works from the captured request, so the result is independent of the issue port.
    lagarto_ld_align u_align (
        .type_i       (type_q),
        .offset_i     (offset_q),
        .rdata_i      (bus.ld_resp_rdata_i),
        .data_o       (align_data),
        .misaligned_o (align_mis)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        capture    = 1'b0;
        load_resp  = 1'b0;
        clear_resp = 1'b0;
        timeout    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ld_fire) begin
                    state_d = WAIT_RESP;
                    cnt_d   = '0;
                    capture = 1'b1;
                end
            end
            WAIT_RESP: begin
                // A response beats the watchdog; a kill with the response drops it.
                if (bus.ld_resp_valid_i && !bus.kill_i) begin
                    state_d   = HOLD;
                    load_resp = 1'b1;
                end else if (bus.ld_resp_valid_i) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (bus.kill_i) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (bus.ld_resp_valid_i) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (bus.resp_ready_i) begin
                    state_d    = IDLE;
                    clear_resp = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            type_q    <= LD;
            offset_q  <= '0;
            rd_q      <= '0;
            resp_q    <= '0;
            st_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            st_done_q <= bus.st_req_valid_i & bus.st_req_gnt_i;
            if (capture) begin
                type_q   <= bus.ld_instr_type_i;
                offset_q <= bus.ld_offset_i;
                rd_q     <= bus.ld_rd_i;
            end
            if (load_resp) begin
                resp_q.valid      <= 1'b1;
                resp_q.data       <= align_data;
                resp_q.rd         <= TAG_W_DEF'(rd_q);
                resp_q.misaligned <= align_mis;
            end else if (clear_resp) begin
                resp_q <= '0;
            end
        end
    end

    assign bus.resp_valid_o      = resp_q.valid;
    assign bus.resp_data_o       = resp_q.data;
    assign bus.resp_rd_o         = TAG_W'(resp_q.rd);
    assign bus.resp_misaligned_o = resp_q.misaligned;
    assign bus.st_done_o         = st_done_q;
    assign bus.busy_o            = (state_q != IDLE);
    assign bus.timeout_o         = timeout;

endmodule
